multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control.sv | 181 ++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control unit: state sequencing, datapath control
// decode, sticky illegal-opcode flag and retired-instruction counter.
module multi_cycle_control #(
  parameter int unsigned MEM_HANDSHAKE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic [1:0]  pc_source,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        illegal,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ADDI_EXEC = 4'd11,
    ADDI_WB   = 4'd12,
    HALT      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t      state_q, state_d;
  logic        illegal_q;
  logic [31:0] instr_count_q;
  logic        ready;
  logic        done;

  assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_source  = 2'd0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    done       = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_RTYPE:      state_d = R_EXEC;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J:          state_d = JUMP;
          OP_ADDI:       state_d = ADDI_EXEC;
          default:       state_d = HALT;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        done       = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (ready) begin
          done    = 1'b1;
          state_d = FETCH;
        end
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        done      = 1'b1;
        state_d   = FETCH;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd1;
        pc_source = 2'd1;
        pc_write  = (opcode == OP_BNE) ? ~zero : zero;
        done      = 1'b1;
        state_d   = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
        done      = 1'b1;
        state_d   = FETCH;
      end
      HALT: state_d = HALT;
      // Unused encodings 14-15 recover to FETCH with all controls low.
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      illegal_q     <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == HALT) illegal_q <= 1'b1;
      if (done) instr_count_q <= instr_count_q + 32'd1;
    end
  end

  assign state       = state_q;
  assign instr_done  = done;
  assign illegal     = illegal_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: directed per-cycle expectations
// are queued by the stimulus and checked by an independent negedge monitor.
module tb_multi_cycle_control;

  logic        clk = 1'b0;
  logic        reset, zero, mem_ready;
  logic [5:0]  opcode;
  logic        pc_write, iord, mem_read, mem_write, ir_write, reg_dst;
  logic        mem_to_reg, reg_write, alu_src_a, instr_done, illegal;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic        r2;
  logic        n_pcw, n_iord, n_mr, n_mw, n_irw, n_rd, n_mtr, n_rw, n_asa, n_done, n_ill;
  logic [1:0]  n_pcs, n_asb, n_aop;
  logic [3:0]  n_state;
  logic [31:0] n_cnt;

  int unsigned checks = 0;
  int unsigned passes = 0;

  always #5 clk = ~clk;

  multi_cycle_control #(.MEM_HANDSHAKE(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_source(pc_source), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .instr_done(instr_done),
    .illegal(illegal), .instr_count(instr_count)
  );

  multi_cycle_control #(.MEM_HANDSHAKE(0)) dut_nh (
    .clk(clk), .reset(r2), .opcode(6'h23), .zero(1'b0), .mem_ready(1'b0),
    .pc_write(n_pcw), .pc_source(n_pcs), .iord(n_iord), .mem_read(n_mr),
    .mem_write(n_mw), .ir_write(n_irw), .reg_dst(n_rd),
    .mem_to_reg(n_mtr), .reg_write(n_rw), .alu_src_a(n_asa),
    .alu_src_b(n_asb), .alu_op(n_aop), .state(n_state), .instr_done(n_done),
    .illegal(n_ill), .instr_count(n_cnt)
  );

  // {pc_write, pc_source, iord, mem_read, mem_write, ir_write, reg_dst,
  //  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op}
  localparam logic [14:0] C_NONE  = 15'h0000;
  localparam logic [14:0] C_FETCH = 15'h4504;
  localparam logic [14:0] C_FSTL  = 15'h0404;
  localparam logic [14:0] C_DEC   = 15'h000C;
  localparam logic [14:0] C_MADDR = 15'h0018;
  localparam logic [14:0] C_MRD   = 15'h0C00;
  localparam logic [14:0] C_MWB   = 15'h0060;
  localparam logic [14:0] C_MWR   = 15'h0A00;
  localparam logic [14:0] C_REX   = 15'h0012;
  localparam logic [14:0] C_RWB   = 15'h00A0;
  localparam logic [14:0] C_AEX   = 15'h0018;
  localparam logic [14:0] C_AWB   = 15'h0020;
  localparam logic [14:0] C_BRT   = 15'h5011;
  localparam logic [14:0] C_BRN   = 15'h1011;
  localparam logic [14:0] C_JMP   = 15'h6000;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [14:0] ctrl;
    logic        done;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  exp_t exq[$];

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
  endtask

  // Monitor: one queued expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exq.size() > 0) begin
      exp_t e;
      logic [14:0] act;
      e   = exq.pop_front();
      act = {pc_write, pc_source, iord, mem_read, mem_write, ir_write, reg_dst,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};
      check({e.name, ".state"}, {28'd0, state}, {28'd0, e.st});
      check({e.name, ".ctrl"},  {17'd0, act},   {17'd0, e.ctrl});
      check({e.name, ".flags"}, {30'd0, instr_done, illegal}, {30'd0, e.done, e.ill});
      check({e.name, ".count"}, instr_count, e.cnt);
    end
  end

  task automatic step(string nm, logic [5:0] op, logic z, logic mr, logic rst,
                      logic [3:0] st, logic [14:0] c, logic d, logic il, logic [31:0] cnt);
    exp_t e;
    @(posedge clk); #1;
    opcode = op; zero = z; mem_ready = mr; reset = rst;
    e.name = nm; e.st = st; e.ctrl = c; e.done = d; e.ill = il; e.cnt = cnt;
    exq.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; r2 = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    // R-type: 0,1,2,7,8,1
    step("r_idle",  6'h00, 0, 1, 0, 4'd0,  C_NONE,  0, 0, 0);
    step("r_fetch", 6'h00, 0, 1, 0, 4'd1,  C_FETCH, 0, 0, 0);
    step("r_dec",   6'h00, 0, 1, 0, 4'd2,  C_DEC,   0, 0, 0);
    step("r_exec",  6'h00, 0, 1, 0, 4'd7,  C_REX,   0, 0, 0);
    step("r_wb",    6'h00, 0, 1, 0, 4'd8,  C_RWB,   1, 0, 0);
    // lw with a fetch stall and a 3-cycle read stall
    step("lw_fstl", 6'h23, 0, 0, 0, 4'd1,  C_FSTL,  0, 0, 1);
    step("lw_fet",  6'h23, 0, 1, 0, 4'd1,  C_FETCH, 0, 0, 1);
    step("lw_dec",  6'h23, 0, 1, 0, 4'd2,  C_DEC,   0, 0, 1);
    step("lw_addr", 6'h23, 0, 1, 0, 4'd3,  C_MADDR, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step("lw_stall", 6'h23, 0, 0, 0, 4'd4, C_MRD, 0, 0, 1);
    step("lw_rd",   6'h23, 0, 1, 0, 4'd4,  C_MRD,   0, 0, 1);
    step("lw_wb",   6'h23, 0, 1, 0, 4'd5,  C_MWB,   1, 0, 1);
    // beq / bne with both zero values
    step("beq1_f",  6'h04, 1, 1, 0, 4'd1,  C_FETCH, 0, 0, 2);
    step("beq1_d",  6'h04, 1, 1, 0, 4'd2,  C_DEC,   0, 0, 2);
    step("beq1_b",  6'h04, 1, 1, 0, 4'd9,  C_BRT,   1, 0, 2);
    step("beq0_f",  6'h04, 0, 1, 0, 4'd1,  C_FETCH, 0, 0, 3);
    step("beq0_d",  6'h04, 0, 1, 0, 4'd2,  C_DEC,   0, 0, 3);
    step("beq0_b",  6'h04, 0, 1, 0, 4'd9,  C_BRN,   1, 0, 3);
    step("bne0_f",  6'h05, 0, 1, 0, 4'd1,  C_FETCH, 0, 0, 4);
    step("bne0_d",  6'h05, 0, 1, 0, 4'd2,  C_DEC,   0, 0, 4);
    step("bne0_b",  6'h05, 0, 1, 0, 4'd9,  C_BRT,   1, 0, 4);
    step("bne1_f",  6'h05, 1, 1, 0, 4'd1,  C_FETCH, 0, 0, 5);
    step("bne1_d",  6'h05, 1, 1, 0, 4'd2,  C_DEC,   0, 0, 5);
    step("bne1_b",  6'h05, 1, 1, 0, 4'd9,  C_BRN,   1, 0, 5);
    // sw with one stall cycle
    step("sw_f",    6'h2B, 0, 1, 0, 4'd1,  C_FETCH, 0, 0, 6);
    step("sw_d",    6'h2B, 0, 1, 0, 4'd2,  C_DEC,   0, 0, 6);
    step("sw_a",    6'h2B, 0, 1, 0, 4'd3,  C_MADDR, 0, 0, 6);
    step("sw_stl",  6'h2B, 0, 0, 0, 4'd6,  C_MWR,   0, 0, 6);
    step("sw_w",    6'h2B, 0, 1, 0, 4'd6,  C_MWR,   1, 0, 6);
    // addi
    step("ai_f",    6'h08, 0, 1, 0, 4'd1,  C_FETCH, 0, 0, 7);
    step("ai_d",    6'h08, 0, 1, 0, 4'd2,  C_DEC,   0, 0, 7);
    step("ai_x",    6'h08, 0, 1, 0, 4'd11, C_AEX,   0, 0, 7);
    step("ai_wb",   6'h08, 0, 1, 0, 4'd12, C_AWB,   1, 0, 7);
    // reset during a MEM_WRITE stall
    step("swr_f",   6'h2B, 0, 1, 0, 4'd1,  C_FETCH, 0, 0, 8);
    step("swr_d",   6'h2B, 0, 1, 0, 4'd2,  C_DEC,   0, 0, 8);
    step("swr_a",   6'h2B, 0, 1, 0, 4'd3,  C_MADDR, 0, 0, 8);
    step("swr_stl", 6'h2B, 0, 0, 1, 4'd6,  C_MWR,   0, 0, 8);
    step("swr_idle",6'h3F, 0, 1, 0, 4'd0,  C_NONE,  0, 0, 0);
    // illegal opcode -> sticky HALT, then reset out of it
    step("ill_f",   6'h3F, 0, 1, 0, 4'd1,  C_FETCH, 0, 0, 0);
    step("ill_d",   6'h3F, 0, 1, 0, 4'd2,  C_DEC,   0, 0, 0);
    for (int i = 0; i < 10; i++)
      step("ill_halt", 6'h3F, 0, 1, 0, 4'd13, C_NONE, 0, 1, 0);
    step("ill_rst", 6'h3F, 0, 1, 1, 4'd13, C_NONE,  0, 1, 0);
    step("ill_idle",6'h02, 0, 1, 0, 4'd0,  C_NONE,  0, 0, 0);
    // 1000 jumps
    for (int i = 0; i < 1000; i++) begin
      step("j_f", 6'h02, 0, 1, 0, 4'd1,  C_FETCH, 0, 0, i);
      step("j_d", 6'h02, 0, 1, 0, 4'd2,  C_DEC,   0, 0, i);
      step("j_j", 6'h02, 0, 1, 0, 4'd10, C_JMP,   1, 0, i);
    end
    step("j_f1000", 6'h02, 0, 1, 0, 4'd1, C_FETCH, 0, 0, 1000);
    @(negedge clk); #1;
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    step("wrap_d",  6'h02, 0, 1, 0, 4'd2,  C_DEC,   0, 0, 32'hFFFF_FFFF);
    step("wrap_j",  6'h02, 0, 1, 0, 4'd10, C_JMP,   1, 0, 32'hFFFF_FFFF);
    step("wrap_f",  6'h02, 0, 1, 0, 4'd1,  C_FETCH, 0, 0, 32'h0000_0000);

    for (int i = 0; i < 10 && exq.size() > 0; i++) @(negedge clk);
    check("queue_drained", exq.size(), 0);

    // No-handshake instance with mem_ready stuck low: two lw in 11 cycles.
    @(posedge clk); #1; r2 = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("nh.count", n_cnt, 32'd2);
    check("nh.state", {28'd0, n_state}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
